// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: default parameters,
// segment bit order and the hex-to-segment table (segments active-high, {g,f,e,d,c,b,a}).
package seven_seg_scan_ctrl_pkg;

    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_DIGIT_CYCLES = 100000;
    localparam int DEF_DEAD_CYCLES  = 16;
    localparam int DEF_PWM_BITS     = 4;
    localparam int DEF_BLINK_FRAMES = 64;
    localparam int DEF_ACTIVE_LOW   = 1;

    typedef enum int {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F = 5,
        SEG_G = 6
    } seg_bit_e;

    typedef logic [6:0] seg_t;

    localparam seg_t HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seven_seg_display_encoder.sv
// Combinational hex nibble to seven-segment pattern, active-high {g,f,e,d,c,b,a}.
module seven_seg_display_encoder
    import seven_seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with frame-atomic double-buffered display
// data, PWM brightness, per-digit blink/blank and dead time between digit slots.
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int DIGIT_CYCLES = DEF_DIGIT_CYCLES,
    parameter int DEAD_CYCLES  = DEF_DEAD_CYCLES,
    parameter int PWM_BITS     = DEF_PWM_BITS,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
    parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   disp_buf,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      load,
    input  logic [PWM_BITS-1:0]       lum,
    output logic [NUM_DIGITS-1:0]     an_mux,
    output logic [6:0]                seg_mux,
    output logic                      dp_mux,
    output logic                      frame_start
);

    localparam int SLOT_W = $clog2(DIGIT_CYCLES);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int FRM_W  = $clog2(BLINK_FRAMES + 1);

    localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]   SLOT_DEAD = SLOT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0]    FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [PWM_BITS-1:0] LUM_FULL  = {PWM_BITS{1'b1}};
    localparam logic                INACT     = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [SLOT_W-1:0]       r_slot;
    logic [IDX_W-1:0]        r_idx;
    logic [PWM_BITS-1:0]     r_pwm_cnt;
    logic [FRM_W-1:0]        r_frame_cnt;
    logic                    r_blink_on;

    logic [4*NUM_DIGITS-1:0] r_pend_buf;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic [NUM_DIGITS-1:0]   r_pend_blink;
    logic                    r_pend_valid;

    logic [4*NUM_DIGITS-1:0] r_act_buf;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic [NUM_DIGITS-1:0]   r_act_blink;

    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_start;

    logic                    w_slot_wrap;
    logic                    w_commit;
    logic                    w_pwm_on;
    logic                    w_visible;
    logic [3:0]              w_nibble;
    logic                    w_dp_sel;
    logic                    w_blank_sel;
    logic                    w_blink_sel;
    logic [NUM_DIGITS-1:0]   w_an_onehot;
    seg_t                    w_seg_raw;

    assign w_slot_wrap = (r_slot == SLOT_LAST);
    // The last cycle of the last digit is the only point where active data may change.
    assign w_commit    = w_slot_wrap && (r_idx == IDX_LAST);

    assign w_nibble    = r_act_buf[{r_idx, 2'b00} +: 4];
    assign w_dp_sel    = r_act_dp[r_idx];
    assign w_blank_sel = r_act_blank[r_idx];
    assign w_blink_sel = r_act_blink[r_idx];
    assign w_an_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;

    // Visibility of the currently selected digit.
    always_comb begin
        w_pwm_on  = (lum == LUM_FULL) || (r_pwm_cnt < lum);
        w_visible = (r_slot >= SLOT_DEAD) && w_pwm_on && !w_blank_sel
                    && (!w_blink_sel || r_blink_on);
    end

    seven_seg_display_encoder u_encoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_raw)
    );

    // Slot, digit index and free-running PWM counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot    <= {SLOT_W{1'b0}};
            r_idx     <= {IDX_W{1'b0}};
            r_pwm_cnt <= {PWM_BITS{1'b0}};
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_slot_wrap) begin
                r_slot <= {SLOT_W{1'b0}};
                r_idx  <= (r_idx == IDX_LAST) ? {IDX_W{1'b0}} : (r_idx + 1'b1);
            end else begin
                r_slot <= r_slot + 1'b1;
            end
        end
    end

    // Blink phase flips after every BLINK_FRAMES frame wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= {FRM_W{1'b0}};
            r_blink_on  <= 1'b1;
        end else if (w_commit) begin
            if (r_frame_cnt == FRM_LAST) begin
                r_frame_cnt <= {FRM_W{1'b0}};
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Pending/active double buffer; a load on the commit cycle bypasses pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_buf   <= {(4*NUM_DIGITS){1'b0}};
            r_pend_dp    <= {NUM_DIGITS{1'b0}};
            r_pend_blank <= {NUM_DIGITS{1'b0}};
            r_pend_blink <= {NUM_DIGITS{1'b0}};
            r_pend_valid <= 1'b0;
            r_act_buf    <= {(4*NUM_DIGITS){1'b0}};
            r_act_dp     <= {NUM_DIGITS{1'b0}};
            r_act_blank  <= {NUM_DIGITS{1'b0}};
            r_act_blink  <= {NUM_DIGITS{1'b0}};
        end else if (w_commit) begin
            r_pend_valid <= 1'b0;
            if (load) begin
                r_act_buf   <= disp_buf;
                r_act_dp    <= dp_mask;
                r_act_blank <= blank_mask;
                r_act_blink <= blink_mask;
            end else if (r_pend_valid) begin
                r_act_buf   <= r_pend_buf;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= r_pend_blank;
                r_act_blink <= r_pend_blink;
            end
        end else if (load) begin
            r_pend_buf   <= disp_buf;
            r_pend_dp    <= dp_mask;
            r_pend_blank <= blank_mask;
            r_pend_blink <= blink_mask;
            r_pend_valid <= 1'b1;
        end
    end

    // Output registers with the polarity inversion folded in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an          <= {NUM_DIGITS{INACT}};
            r_seg         <= {7{INACT}};
            r_dp          <= INACT;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_commit;
            if (w_visible) begin
                r_an  <= w_an_onehot ^ {NUM_DIGITS{INACT}};
                r_seg <= w_seg_raw ^ {7{INACT}};
                r_dp  <= w_dp_sel ^ INACT;
            end else begin
                r_an  <= {NUM_DIGITS{INACT}};
                r_seg <= {7{INACT}};
                r_dp  <= INACT;
            end
        end
    end

    assign an_mux      = r_an;
    assign seg_mux     = r_seg;
    assign dp_mux      = r_dp;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: every cycle the pins are compared with a reference model that
// derives slot/digit/PWM/blink purely from elapsed cycles and a time-stamped load log.
`timescale 1ns/1ps
module tb_seven_seg_scan_ctrl;

    localparam int ND   = 4;
    localparam int DC   = 64;
    localparam int DEAD = 4;
    localparam int PB   = 4;
    localparam int BF   = 2;
    localparam int FR   = ND * DC;

    localparam logic [6:0] HEX_REF [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    typedef struct {
        int          t;
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
    } load_rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   disp_buf = 16'h0000;
    logic [3:0]    dp_mask = 4'h0;
    logic [3:0]    blank_mask = 4'h0;
    logic [3:0]    blink_mask = 4'h0;
    logic          load = 1'b0;
    logic [PB-1:0] lum = 4'hF;
    logic [3:0]    an_mux;
    logic [6:0]    seg_mux;
    logic          dp_mux;
    logic          frame_start;

    load_rec_t loads[$];
    int n_cmp   = 0;
    int n_fail  = 0;
    int t_state = 0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .DIGIT_CYCLES (DC),
        .DEAD_CYCLES  (DEAD),
        .PWM_BITS     (PB),
        .BLINK_FRAMES (BF),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .disp_buf    (disp_buf),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .load        (load),
        .lum         (lum),
        .an_mux      (an_mux),
        .seg_mux     (seg_mux),
        .dp_mux      (dp_mux),
        .frame_start (frame_start)
    );

    // Expected pins for the counter state t cycles after reset, given lum during that cycle.
    function automatic void model(input int t, input logic [3:0] l,
                                  output logic [3:0] an_e, output logic [6:0] seg_e,
                                  output logic dp_e, output logic vis);
        int slot, d, frame, pwm;
        logic [15:0] data;
        logic [3:0] dpm, blk, bln;
        logic phase_on;
        slot  = t % DC;
        d     = (t / DC) % ND;
        frame = t / FR;
        pwm   = t % (1 << PB);
        data  = 16'h0000;
        dpm   = 4'h0;
        blk   = 4'h0;
        bln   = 4'h0;
        foreach (loads[i]) begin
            if (loads[i].t / FR < frame) begin
                data = loads[i].data;
                dpm  = loads[i].dp;
                blk  = loads[i].blank;
                bln  = loads[i].blink;
            end
        end
        phase_on = ((frame / BF) % 2) == 0;
        vis   = (slot >= DEAD) && ((l == 4'hF) || (pwm < int'(l))) && !blk[d]
                && (!bln[d] || phase_on);
        an_e  = vis ? ~(4'b0001 << d) : 4'b1111;
        seg_e = ~HEX_REF[data[d*4 +: 4]];
        dp_e  = ~dpm[d];
    endfunction

    task automatic cycle();
        logic [3:0] l_k, an_e;
        logic [6:0] seg_e;
        logic dp_e, vis, fs_e;
        load_rec_t r;
        if (load) begin
            r.t = t_state; r.data = disp_buf; r.dp = dp_mask;
            r.blank = blank_mask; r.blink = blink_mask;
            loads.push_back(r);
        end
        l_k = lum;
        @(posedge clk);
        t_state++;
        @(negedge clk);
        model(t_state - 1, l_k, an_e, seg_e, dp_e, vis);
        fs_e = (t_state % FR) == 0;
        n_cmp++;
        assert (an_mux === an_e) else begin
            n_fail++;
            $error("FAIL an_mux t=%0d: got %b expected %b", t_state - 1, an_mux, an_e);
        end
        n_cmp++;
        assert (frame_start === fs_e) else begin
            n_fail++;
            $error("FAIL frame_start t=%0d: got %b expected %b", t_state, frame_start, fs_e);
        end
        if (vis) begin
            n_cmp++;
            assert (seg_mux === seg_e) else begin
                n_fail++;
                $error("FAIL seg_mux t=%0d: got %b expected %b", t_state - 1, seg_mux, seg_e);
            end
            n_cmp++;
            assert (dp_mux === dp_e) else begin
                n_fail++;
                $error("FAIL dp_mux t=%0d: got %b expected %b", t_state - 1, dp_mux, dp_e);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic align(input int phase);
        while ((t_state % FR) != phase) cycle();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] bk, input logic [3:0] bl);
        disp_buf = d; dp_mask = dp; blank_mask = bk; blink_mask = bl;
        load = 1'b1;
        cycle();
        load = 1'b0;
        disp_buf = 16'($urandom);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        assert (an_mux === 4'b1111) else begin
            n_fail++; $error("FAIL reset_an: got %b expected 1111", an_mux);
        end
        n_cmp++;
        assert (seg_mux === 7'b1111111) else begin
            n_fail++; $error("FAIL reset_seg: got %b expected 1111111", seg_mux);
        end
        n_cmp++;
        assert (dp_mux === 1'b1) else begin
            n_fail++; $error("FAIL reset_dp: got %b expected 1", dp_mux);
        end
        n_cmp++;
        assert (frame_start === 1'b0) else begin
            n_fail++; $error("FAIL reset_frame_start: got %b expected 0", frame_start);
        end
        loads.delete();
        t_state = 0;
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        do_reset();
        run(FR);

        // Basic scan of 1234 with full brightness.
        run($urandom_range(10, 120));
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        run(2 * FR);

        // Two loads in one frame: latest wins, current frame untouched.
        align(0);
        run(40);
        do_load(16'hAAAA, 4'b0101, 4'b0000, 4'b0000);
        run(60);
        do_load(16'h5555, 4'b1010, 4'b0000, 4'b0000);
        run(2 * FR);

        // Load exactly on the commit cycle.
        align(FR - 1);
        do_load(16'($urandom), 4'($urandom), 4'b0000, 4'b0000);
        run(FR + 8);

        // PWM brightness: partial and dark.
        lum = 4'd4;
        run(FR);
        lum = 4'd0;
        run(FR);
        lum = 4'hF;

        // Blink digit 0, blank digit 3.
        do_load(16'h9876, 4'b0011, 4'b1000, 4'b0001);
        run(6 * FR);

        // Randomized loads, masks and brightness.
        repeat (8) begin
            lum = 4'($urandom);
            run($urandom_range(20, 300));
            do_load(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end
        repeat (FR) begin
            lum = 4'($urandom);
            cycle();
        end

        // Reset mid-slot with a load pending.
        lum = 4'hF;
        align(0);
        run(100);
        do_load(16'hBEEF, 4'b1111, 4'b0000, 4'b0000);
        run(10);
        do_reset();
        run(FR + 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 The block SHALL have a parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 The block SHALL have a parameter DIGIT_CYCLES, default 100000: clk cycles per digit slot, minimum 32.
REQ-003 The block SHALL have a parameter DEAD_CYCLES, default 16: all-anodes-off cycles at the start of each slot, less than DIGIT_CYCLES.
REQ-004 The block SHALL have a parameter PWM_BITS, default 4: brightness resolution.
REQ-005 The block SHALL have a parameter BLINK_FRAMES, default 64: frames per blink half-period, minimum 1.
REQ-006 The block SHALL have a parameter ACTIVE_LOW, default 1: 1 means anodes, segments and dp are driven low when active.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port disp_buf, input, 4*NUM_DIGITS bits: hex nibbles, with digit i at [4i+3:4i].
REQ-010 The block SHALL have port dp_mask, input, NUM_DIGITS bits: per-digit decimal point enable.
REQ-011 The block SHALL have port blank_mask, input, NUM_DIGITS bits: per-digit force-off.
REQ-012 The block SHALL have port blink_mask, input, NUM_DIGITS bits: per-digit blink enable.
REQ-013 The block SHALL have port load, input, 1 bit: single-cycle strobe that captures disp_buf and the three masks.
REQ-014 The block SHALL have port lum, input, PWM_BITS bits: brightness; it is used directly and is not shadowed.
REQ-015 The block SHALL have port an_mux, output, NUM_DIGITS bits: anode drivers, registered.
REQ-016 The block SHALL have port seg_mux, output, 7 bits: cathodes {g,f,e,d,c,b,a}, registered.
REQ-017 The block SHALL have port dp_mux, output, 1 bit: decimal point driver, registered.
REQ-018 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse when the digit index wraps to 0.

Function
REQ-019 The slot counter SHALL count 0..DIGIT_CYCLES-1 and wrap to 0.
- The digit index SHALL increment on each slot-counter wrap and wrap from NUM_DIGITS-1 to 0.
REQ-020 The block SHALL keep pending registers and active registers for the display data.
- Pending registers SHALL capture disp_buf and the masks on load, and a pending flag SHALL be set.
- If load repeats before a commit, the latest load SHALL win.
REQ-021 The commit SHALL occur on the cycle where index==NUM_DIGITS-1 and slot==DIGIT_CYCLES-1.
- If the pending flag is set, pending SHALL be copied to active and the flag cleared.
- If load is asserted on the commit cycle itself, the load data SHALL go directly to active.
- A frame SHALL never mix old and new data.
REQ-022 frame_start SHALL assert for exactly one cycle, coincident with the cycle where the index becomes 0.
REQ-023 The free-running PWM counter SHALL be PWM_BITS wide.
- pwm_on SHALL be true when lum equals all-ones, or when pwm_cnt < lum.
- lum==0 SHALL give a dark display.
REQ-024 The blink phase SHALL start "on" and toggle every BLINK_FRAMES frame_start pulses.
REQ-025 The selected digit d SHALL be visible when all of the following hold:
- slot >= DEAD_CYCLES;
- pwm_on;
- blank_mask[d]==0;
- blink_mask[d]==0 or the blink phase is on.
REQ-026 When digit d is visible, an_mux SHALL be one-hot on bit d; otherwise all anodes SHALL be inactive.
REQ-027 seg_mux SHALL carry the hex encoding (0-F) of active nibble d. dp_mux SHALL be active iff dp_mask[d]==1.
REQ-028 All three display outputs SHALL be registered, with 1-cycle latency from counter state to pins.
- The ACTIVE_LOW inversion SHALL be applied at the output registers.
REQ-029 Segment and dp values outside the visible window are don't-care; anodes inactive are mandatory.

Reset
REQ-030 While rst is high, the following SHALL be cleared to 0 on the next clk edge:
- slot counter, index, PWM counter and frame counter;
- active and pending registers, and the pending flag.
REQ-031 Reset SHALL also apply these values on the same edge:
- blink phase on;
- an_mux, seg_mux and dp_mux all inactive (all-ones when ACTIVE_LOW=1);
- frame_start 0.
REQ-032 Reset mid-frame SHALL discard any pending load. After release, scanning SHALL restart at digit 0, slot 0.

Structure
REQ-033 A shared package/include SHALL hold the 16-entry hex-to-segment constant table, the segment bit order, and the default parameter values.
REQ-034 Hex encoding SHALL be the one sub-module, the existing seven_seg_display_encoder, instantiated once. All other logic SHALL be inline.

Verification
REQ-035 Scenario: NUM_DIGITS=4, DIGIT_CYCLES=64, DEAD_CYCLES=4, lum=4'hF, load disp_buf=16'h1234.
- Required response from the frame after commit: digits 0..3 show 4,3,2,1.
- an_mux SHALL be 1110, 1101, 1011, 0111, each asserted for 60 cycles after 4 dead cycles.
REQ-036 Scenario: load 16'hAAAA mid-frame, then load 16'h5555 before the frame ends.
- Required response: the current frame is unchanged and the next frame shows only 5.
REQ-037 Scenario: load asserted on the exact commit cycle.
- Required response: digit 0 of the next frame shows the new data.
REQ-038 Scenario: lum=4 with PWM_BITS=4.
- Required response: anodes active 4 of every 16 cycles in the visible window.
- lum=0 SHALL give zero anode-active cycles.
REQ-039 Scenario: blink_mask=4'b0001, BLINK_FRAMES=2.
- Required response: digit 0 is dark for 2 frames and lit for 2 frames, alternating.
- blank_mask=4'b1000 SHALL keep digit 3 always dark.
REQ-040 Scenario: rst asserted mid-slot with a load pending.
- Required response: all outputs inactive on the next edge.
- After release, the first frame_start SHALL come 4*64 cycles later and the display SHALL show 0000.
